// File: rtl/alu_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : alu_rr_sched
// Purpose  : Round-robin scheduler sharing one DW-bit ALU (add, sub, and, or,
//            shl, shr) between two valid/ready command sources.  One command
//            is executed at a time and its tagged, registered result is
//            returned on a single response channel with backpressure.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   ena          in   global enable; low blocks new grants only
//   reqN_valid   in   requester N command valid          (N = 0, 1)
//   reqN_ready   out  requester N command accepted this cycle
//   reqN_op      in   requester N opcode (3 bits)
//   reqN_a/b     in   requester N operands (DW bits)
//   rsp_valid    out  response valid
//   rsp_ready    in   response consumer ready
//   rsp_id       out  index of the requester owning the response
//   rsp_data     out  ALU result (DW bits)
//   rsp_err      out  illegal opcode flag
//   busy         out  high whenever the scheduler is not idle
//   rsp_carry    out  carry/borrow/shifted-out bit   (ALU_FLAGS_EN only)
//   rsp_zero     out  result-is-zero flag             (ALU_FLAGS_EN only)
// ----------------------------------------------------------------------------
// Configuration macro
//   ALU_FLAGS_EN : when defined, adds the registered rsp_carry / rsp_zero
//                  outputs.  When undefined those ports and their logic are
//                  absent and all other behaviour is identical.
// ============================================================================
module alu_rr_sched #(
    parameter int   DW      = 8,
    parameter logic RST_PTR = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,

    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [2:0]    req0_op,
    input  logic [DW-1:0] req0_a,
    input  logic [DW-1:0] req0_b,

    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [2:0]    req1_op,
    input  logic [DW-1:0] req1_a,
    input  logic [DW-1:0] req1_b,

    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
`ifdef ALU_FLAGS_EN
    output logic          rsp_carry,
    output logic          rsp_zero,
`endif
    output logic          busy
);

    // ------------------------------------------------------------------------
    // Opcodes
    // ------------------------------------------------------------------------
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_SHL = 3'd4;
    localparam logic [2:0] OP_SHR = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          ptr_q, ptr_d;       // requester granted most recently

    logic [2:0]    op_q;
    logic [DW-1:0] a_q;
    logic [DW-1:0] b_q;
    logic          id_q;

    logic [DW-1:0] rsp_data_q;
    logic          rsp_err_q;
    logic          rsp_id_q;

    logic          grant;
    logic          accept;
    logic [DW-1:0] alu_res;
    logic          alu_err;

    // ------------------------------------------------------------------------
    // Arbitration.  A lone valid requester wins; on contention (or when no
    // one is asking) the requester that was not granted last is preferred.
    // ------------------------------------------------------------------------
    always_comb begin
        grant = ~ptr_q;
        if (req0_valid && !req1_valid) begin
            grant = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            grant = 1'b1;
        end
    end

    assign req0_ready = (state_q == ST_IDLE) && ena && (grant == 1'b0);
    assign req1_ready = (state_q == ST_IDLE) && ena && (grant == 1'b1);
    assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_EXEC;
                    ptr_d   = grant;   // pointer moves only on a real transfer
                end
            end
            ST_EXEC: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= RST_PTR;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // ------------------------------------------------------------------------
    // Command capture: operands are frozen at acceptance so later changes on
    // the request pins cannot disturb the command in flight.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q <= 3'd0;
            a_q  <= '0;
            b_q  <= '0;
            id_q <= 1'b0;
        end else if ((state_q == ST_IDLE) && accept) begin
            id_q <= grant;
            if (grant) begin
                op_q <= req1_op;
                a_q  <= req1_a;
                b_q  <= req1_b;
            end else begin
                op_q <= req0_op;
                a_q  <= req0_a;
                b_q  <= req0_b;
            end
        end
    end

    // ------------------------------------------------------------------------
    // ALU datapath (operates on captured operands)
    // ------------------------------------------------------------------------
    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (op_q)
            OP_ADD:  alu_res = a_q + b_q;
            OP_SUB:  alu_res = a_q - b_q;
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_SHL:  alu_res = {a_q[DW-2:0], 1'b0};
            OP_SHR:  alu_res = {1'b0, a_q[DW-1:1]};
            default: alu_err = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------------
    // Response registers: loaded once in EXEC, then held (including after the
    // handshake) until the next command executes.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            rsp_id_q   <= 1'b0;
        end else if (state_q == ST_EXEC) begin
            rsp_data_q <= alu_res;
            rsp_err_q  <= alu_err;
            rsp_id_q   <= id_q;
        end
    end

`ifdef ALU_FLAGS_EN
    logic [DW:0] add_wide;
    logic        alu_carry;
    logic        rsp_carry_q;
    logic        rsp_zero_q;

    assign add_wide = {1'b0, a_q} + {1'b0, b_q};

    always_comb begin
        alu_carry = 1'b0;
        case (op_q)
            OP_ADD:  alu_carry = add_wide[DW];
            OP_SUB:  alu_carry = (a_q < b_q);     // borrow
            OP_SHL:  alu_carry = a_q[DW-1];
            OP_SHR:  alu_carry = a_q[0];
            default: alu_carry = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_carry_q <= 1'b0;
            rsp_zero_q  <= 1'b0;
        end else if (state_q == ST_EXEC) begin
            rsp_carry_q <= alu_carry;
            rsp_zero_q  <= (alu_res == '0);       // illegal ops give zero too
        end
    end

    assign rsp_carry = rsp_carry_q;
    assign rsp_zero  = rsp_zero_q;
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign rsp_valid = (state_q == ST_RESP);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_id    = rsp_id_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_rr_sched
// Purpose  : Self-checking bench for alu_rr_sched.  A transaction-level
//            reference model (queue of outstanding expected responses plus
//            the round-robin pointer) predicts every output each cycle.
//            Directed scenarios are followed by randomized traffic and an
//            asynchronous reset taken while a response is pending.
// Revision : 1.0 - initial release
// Macro    : ALU_FLAGS_EN also enables the flag outputs and their checks.
// ============================================================================
module tb_alu_rr_sched;

    localparam int   DW      = 8;
    localparam logic RST_PTR = 1'b1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ena;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [2:0]    req0_op, req1_op;
    logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
    logic          rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [DW-1:0] rsp_data;
`ifdef ALU_FLAGS_EN
    logic          rsp_carry, rsp_zero;
`endif

    alu_rr_sched #(.DW(DW), .RST_PTR(RST_PTR)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
`ifdef ALU_FLAGS_EN
        .rsp_carry  (rsp_carry),
        .rsp_zero   (rsp_zero),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------------
    typedef struct {
        logic [7:0] d;
        logic       id;
        logic       err;
        logic       c;
        logic       z;
        int         t;     // cycle of acceptance
    } exp_t;

    exp_t q[$];            // accepted, not yet delivered
    exp_t last;            // most recently delivered response
    logic ptr;
    int   cyc;
    int   n_checks;
    int   n_errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t alu_ref(input int op, input int a, input int b, input logic id);
        exp_t e;
        int   r;
        e   = '{d: 8'd0, id: id, err: 1'b0, c: 1'b0, z: 1'b0, t: 0};
        r   = 0;
        case (op)
            0: begin r = (a + b) % 256;       e.c = ((a + b) > 255); end
            1: begin r = (a - b + 256) % 256; e.c = (a < b);         end
            2: r = a & b;
            3: r = a | b;
            4: begin r = (a * 2) % 256;       e.c = (a >= 128);      end
            5: begin r = a / 2;               e.c = ((a % 2) == 1);  end
            default: e.err = 1'b1;
        endcase
        e.d = 8'(r);
        e.z = (r == 0);
        return e;
    endfunction

    function automatic void model_reset();
        q.delete();
        ptr  = RST_PTR;
        last = '{d: 8'd0, id: 1'b0, err: 1'b0, c: 1'b0, z: 1'b0, t: 0};
    endfunction

    // One clock cycle: check all outputs mid-cycle against the model, advance
    // the model with the inputs that the coming edge will see, then take the
    // edge.  Entered and left at posedge+1.
    task automatic step();
        logic idle, g, r0, r1, rv, acc;
        exp_t e;
        #3;
        idle = (q.size() == 0);
        if (req0_valid && !req1_valid)      g = 1'b0;
        else if (req1_valid && !req0_valid) g = 1'b1;
        else                                g = ~ptr;
        r0 = idle && ena && !g;
        r1 = idle && ena && g;
        if (req0_valid || req1_valid) begin
            check("req0_ready", 32'(req0_ready), 32'(r0));
            check("req1_ready", 32'(req1_ready), 32'(r1));
        end
        rv = !idle && (cyc >= q[0].t + 2);
        check("rsp_valid", 32'(rsp_valid), 32'(rv));
        check("busy", 32'(busy), 32'(!idle));
        e = rv ? q[0] : last;
        check("rsp_data", 32'(rsp_data), 32'(e.d));
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_err", 32'(rsp_err), 32'(e.err));
`ifdef ALU_FLAGS_EN
        check("rsp_carry", 32'(rsp_carry), 32'(e.c));
        check("rsp_zero", 32'(rsp_zero), 32'(e.z));
`endif
        acc = (req0_valid && r0) || (req1_valid && r1);
        if (rv && rsp_ready) begin
            last = q.pop_front();
        end
        if (acc) begin
            if (g) e = alu_ref(int'(req1_op), int'(req1_a), int'(req1_b), 1'b1);
            else   e = alu_ref(int'(req0_op), int'(req0_a), int'(req0_b), 1'b0);
            e.t = cyc;
            q.push_back(e);
            ptr = g;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive0(input logic v, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    endtask

    task automatic drive1(input logic v, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        model_reset();
        rst_n     = 1'b0;
        ena       = 1'b1;
        rsp_ready = 1'b1;
        drive0(1'b0, 3'd0, 8'h00, 8'h00);
        drive1(1'b0, 3'd0, 8'h00, 8'h00);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        rst_n = 1'b1;

        // req0 alone: add 0xF0 + 0x20
        drive0(1'b1, 3'd0, 8'hF0, 8'h20);
        step();
        drive0(1'b0, 3'd0, 8'h00, 8'h00);
        repeat (4) step();

        // Continuous contention, AND 0xCC & 0x0F from both sides
        drive0(1'b1, 3'd2, 8'hCC, 8'h0F);
        drive1(1'b1, 3'd2, 8'hCC, 8'h0F);
        repeat (14) step();
        drive0(1'b0, 3'd0, 8'h00, 8'h00);
        drive1(1'b0, 3'd0, 8'h00, 8'h00);
        repeat (3) step();

        // Response stall: SUB 0x05 - 0x07 held for several cycles
        rsp_ready = 1'b0;
        drive0(1'b1, 3'd1, 8'h05, 8'h07);
        step();
        drive0(1'b1, 3'd3, 8'hAA, 8'h55);   // keeps requesting during the stall
        drive1(1'b1, 3'd0, 8'h11, 8'h22);
        repeat (7) step();
        rsp_ready = 1'b1;
        drive0(1'b0, 3'd0, 8'h00, 8'h00);
        drive1(1'b0, 3'd0, 8'h00, 8'h00);
        repeat (6) step();

        // Illegal op and shifts from req1
        drive1(1'b1, 3'd6, 8'h12, 8'h34);
        step();
        drive1(1'b0, 3'd0, 8'h00, 8'h00);
        repeat (3) step();
        drive1(1'b1, 3'd5, 8'h81, 8'hFF);
        step();
        drive1(1'b0, 3'd0, 8'h00, 8'h00);
        repeat (3) step();
        drive1(1'b1, 3'd4, 8'h81, 8'hFF);
        step();
        drive1(1'b0, 3'd0, 8'h00, 8'h00);
        repeat (3) step();

        // ena gating of grants, and ena dropped while executing
        ena = 1'b0;
        drive0(1'b1, 3'd3, 8'h30, 8'h03);
        repeat (3) step();
        ena = 1'b1;
        step();
        ena = 1'b0;
        drive0(1'b0, 3'd0, 8'h00, 8'h00);
        repeat (4) step();
        ena = 1'b1;
        step();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            ena       = ($urandom_range(0, 7) != 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            drive0(1'($urandom), 3'($urandom), 8'($urandom), 8'($urandom));
            drive1(1'($urandom), 3'($urandom), 8'($urandom), 8'($urandom));
            step();
        end

        // Drain, then asynchronous reset while a response is pending
        ena = 1'b1;
        rsp_ready = 1'b1;
        drive0(1'b0, 3'd0, 8'h00, 8'h00);
        drive1(1'b0, 3'd0, 8'h00, 8'h00);
        repeat (4) step();
        rsp_ready = 1'b0;
        drive0(1'b1, 3'd0, 8'h01, 8'h01);
        step();
        drive0(1'b0, 3'd0, 8'h00, 8'h00);
        repeat (3) step();
        check("pre_rst_rsp_valid", 32'(rsp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_rsp_data", 32'(rsp_data), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        rsp_ready = 1'b1;

        // First contention after reset goes to req0
        drive0(1'b1, 3'd3, 8'h0F, 8'hF0);
        drive1(1'b1, 3'd2, 8'h0F, 8'hF0);
        check("post_rst_req0_ready", 32'(req0_ready), 32'd1);
        repeat (8) step();
        drive0(1'b0, 3'd0, 8'h00, 8'h00);
        drive1(1'b0, 3'd0, 8'h00, 8'h00);
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
